sat_addsub_serial: RTL



---
 rtl/alu_pkg.sv | 32 +++
 rtl/cla_4bit.sv | 34 +++
 rtl/sat_addsub_serial.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, saturation limits and the serial unit's state encoding.
// Also provides the saturation mux used when a result is committed.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int NIBS  = WIDTH / NIB;

    localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // On overflow the sign of A tells which rail was crossed.
    function automatic logic [WIDTH-1:0] sat_result(
        input logic [WIDTH-1:0] raw,
        input logic             ovf,
        input logic             a_sign
    );
        if (!ovf)
            return raw;
        else if (a_sign)
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice: all carries are flattened sum-of-products of the
// generate/propagate terms, so no carry ripples between bit positions.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sum
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign cout = c[4];

endmodule

// File: rtl/sat_addsub_serial.sv
// Nibble-serial 16-bit saturating add/sub: one shared 4-bit CLA slice runs for four
// cycles, then the saturated result, raw carry and overflow flag are held until consumed.
module sat_addsub_serial
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] raw_reg;
    logic             carry_reg;
    logic [1:0]       cnt_reg;

    logic [NIB-1:0]   slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] raw_full;
    logic             ovf;

    cla_4bit u_slice (
        .a    (a_reg[cnt_reg*NIB +: NIB]),
        .b    (b_reg[cnt_reg*NIB +: NIB]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Only meaningful on the last nibble: the top slice is still on the slice output.
    assign raw_full = {slice_sum, raw_reg[WIDTH-NIB-1:0]};
    assign ovf      = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (raw_full[WIDTH-1] != a_reg[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            v         <= 1'b0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            raw_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                        in_ready  <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    raw_reg[cnt_reg*NIB +: NIB] <= slice_sum;
                    carry_reg                   <= slice_cout;
                    cnt_reg                     <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        sum       <= sat_result(raw_full, ovf, a_reg[WIDTH-1]);
                        cout      <= slice_cout;
                        v         <= ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
